// File: rtl/jt1943_sndcmd.sv
// Main-to-sound command path: 4-deep command FIFO read by the sound CPU, a main-side
// sound-reset register and the periodic sound interrupt timed by the 3 MHz enable.
module jt1943_sndcmd #(
    parameter int INT_PERIOD = 12500,
    parameter int INT_WIDTH  = 16,
    parameter int AW         = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen3,
    input  logic       main_cen,
    input  logic [7:0] main_dout,
    input  logic       main_latch_cs,
    input  logic       main_sres_cs,
    input  logic       snd_latch_rd,
    output logic [7:0] latch,
    output logic       sres_b,
    output logic       snd_int,
    output logic       full,
    output logic       empty,
    output logic       ovf
);

    localparam int              DEPTH    = 2**AW;
    localparam int              CW       = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
    localparam logic [CW-1:0]   TMR_LAST = CW'(INT_PERIOD - 1);
    localparam logic [CW-1:0]   TMR_HI   = CW'(INT_WIDTH);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    latch_q, latch_d;
    logic          ovf_q, ovf_d;
    logic          sres_q, sres_d;
    logic          rdly_q, rdly_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic          int_q, int_d;

    logic          push_req, pop_req, push_fire, pop_fire;
    logic          full_c, empty_c;

    always_comb begin
        push_req  = main_latch_cs & main_cen;
        pop_req   = snd_latch_rd & ~rdly_q;
        full_c    = (cnt_q == CNT_FULL);
        empty_c   = (cnt_q == '0);
        pop_fire  = pop_req & ~empty_c;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push_fire = push_req & (~full_c | pop_fire);

        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        ovf_d   = ovf_q;
        sres_d  = sres_q;
        rdly_d  = snd_latch_rd;
        tmr_d   = tmr_q;
        int_d   = int_q;

        if (main_sres_cs & main_cen)
            sres_d = main_dout[0];

        if (!sres_q) begin
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            latch_d = 8'h00;
            ovf_d   = 1'b0;
            tmr_d   = '0;
            int_d   = 1'b0;
        end else begin
            if (!empty_c)
                latch_d = mem_q[rd_q];
            if (push_fire) begin
                mem_d[wr_q] = main_dout;
                wr_d        = wr_q + 1'b1;
            end
            if (pop_fire)
                rd_d = rd_q + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (push_req & full_c & ~pop_fire)
                ovf_d = 1'b1;
            if (cen3) begin
                int_d = (tmr_q < TMR_HI);
                tmr_d = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            latch_q <= 8'h00;
            ovf_q   <= 1'b0;
            sres_q  <= 1'b0;
            rdly_q  <= 1'b0;
            tmr_q   <= '0;
            int_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            ovf_q   <= ovf_d;
            sres_q  <= sres_d;
            rdly_q  <= rdly_d;
            tmr_q   <= tmr_d;
            int_q   <= int_d;
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign latch   = latch_q;
    assign sres_b  = sres_q;
    assign snd_int = int_q;
    assign full    = full_c;
    assign empty   = empty_c;
    assign ovf     = ovf_q;

endmodule
